// File: rtl/fpu_types_pkg.sv
// Shared types and exponent arithmetic for the FPU exponent datapath.
package fpu_types_pkg;

    localparam logic [7:0] EXP_BIAS = 8'd128;

    typedef struct packed {
        logic [7:0] sum;
        logic       ovf;
        logic       unf;
    } exp_res_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

    // Biased add: sum = exp1 + exp2 - bias (mod 256), with range flags taken
    // from the unbiased operands. A mantissa carry that lifts an all-ones
    // sum back into range cancels the underflow.
    function automatic exp_res_t exp_add(input logic [7:0] exp1,
                                         input logic [7:0] exp2,
                                         input logic       carry);
        exp_res_t   res;
        logic [7:0] r1;
        logic [7:0] r2;
        logic [7:0] rs;
        r1      = exp1 - EXP_BIAS;
        r2      = exp2 - EXP_BIAS;
        rs      = r1 + r2;
        res.sum = exp1 + exp2 - EXP_BIAS;
        res.ovf = rs[7] & ~r1[7] & ~r2[7];
        res.unf = (~carry | (res.sum != 8'hFF)) & ~rs[7] & r1[7] & r2[7];
        return res;
    endfunction

endpackage

// File: rtl/fp_exp_arbiter_rr_picker.sv
// Round-robin priority encoder: first asserted request at or after ptr.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    int   idx;
    logic found;

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ; take the first hit.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_exp_arbiter.sv
// Round-robin arbiter sharing one biased-exponent adder among FPU requesters.
// Result is registered (1-cycle latency) and tagged with the requester index.
//
// state    | meaning
// ST_EMPTY | result register empty, res_valid=0
// ST_FULL  | result register holds a result, res_valid=1
module fp_exp_arbiter
    import fpu_types_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*8-1:0]   req_exp1,
    input  logic [NUM_REQ*8-1:0]   req_exp2,
    input  logic [NUM_REQ-1:0]     req_carry,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [7:0]             res_sum,
    output logic                   res_ovf,
    output logic                   res_unf,
    output logic                   busy
);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     rr_ptr_nxt;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_W-1:0]     pick_idx;
    logic                can_accept;
    logic                transfer;
    exp_res_t            op_res;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx)
    );

    // Skid-free pipeline: a new result may enter as the old one leaves.
    assign can_accept = (state == ST_EMPTY) | res_ready;

    assign op_res = exp_add(req_exp1[int'(pick_idx)*8 +: 8],
                            req_exp2[int'(pick_idx)*8 +: 8],
                            req_carry[pick_idx]);

    // State, pointer and result register; results only load on a transfer.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state   <= ST_EMPTY;
            rr_ptr  <= '0;
            res_id  <= '0;
            res_sum <= '0;
            res_ovf <= 1'b0;
            res_unf <= 1'b0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            if (transfer) begin
                res_id  <= pick_idx;
                res_sum <= op_res.sum;
                res_ovf <= op_res.ovf;
                res_unf <= op_res.unf;
            end
        end
    end

    // Next state and pointer advance past the winner on each transfer.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        transfer   = |req_ready;
        if (transfer) begin
            state_nxt  = ST_FULL;
            rr_ptr_nxt = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
        end else if (can_accept) begin
            state_nxt = ST_EMPTY;
        end
    end

    // Handshake outputs; grants are suppressed while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (nRST && can_accept) begin
            req_ready = pick_grant;
        end
        res_valid = (state == ST_FULL);
        busy      = (state == ST_FULL) & ~res_ready;
    end

endmodule

// File: tb/tb_fp_exp_arbiter.sv
// Directed bench for fp_exp_arbiter: a 2-requester and a 3-requester instance.
module tb_fp_exp_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;

    logic [1:0]  rv2, rdy2, c2;
    logic [15:0] e1_2, e2_2;
    logic        resv2, resr2, ovf2, unf2, busy2;
    logic [0:0]  id2;
    logic [7:0]  sum2;

    logic [2:0]  rv3, rdy3, c3;
    logic [23:0] e1_3, e2_3;
    logic        resv3, resr3, ovf3, unf3, busy3;
    logic [1:0]  id3;
    logic [7:0]  sum3;

    int vectors   = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    fp_exp_arbiter #(.NUM_REQ(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .req_valid(rv2), .req_ready(rdy2),
        .req_exp1(e1_2), .req_exp2(e2_2), .req_carry(c2),
        .res_valid(resv2), .res_ready(resr2), .res_id(id2), .res_sum(sum2),
        .res_ovf(ovf2), .res_unf(unf2), .busy(busy2)
    );

    fp_exp_arbiter #(.NUM_REQ(3)) dut3 (
        .CLK(CLK), .nRST(nRST), .req_valid(rv3), .req_ready(rdy3),
        .req_exp1(e1_3), .req_exp2(e2_3), .req_carry(c3),
        .res_valid(resv3), .res_ready(resr3), .res_id(id3), .res_sum(sum3),
        .res_ovf(ovf3), .res_unf(unf3), .busy(busy3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_res2(input string tag, input logic v, input logic id,
                              input logic [7:0] s, input logic o, input logic u);
        check({tag, "_valid"}, 32'(resv2), 32'(v));
        check({tag, "_id"},    32'(id2),   32'(id));
        check({tag, "_sum"},   32'(sum2),  32'(s));
        check({tag, "_ovf"},   32'(ovf2),  32'(o));
        check({tag, "_unf"},   32'(unf2),  32'(u));
    endtask

    initial begin
        nRST = 1'b0;
        rv2 = 2'b11; c2 = '0; e1_2 = '0; e2_2 = '0; resr2 = 1'b1;
        rv3 = '0;    c3 = '0; e1_3 = '0; e2_3 = '0; resr3 = 1'b1;

        // reset state
        tick(); tick();
        check("rst_ready", 32'(rdy2), 32'h0);
        check_res2("rst", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rst_busy", 32'(busy2), 32'h0);
        nRST = 1'b1; rv2 = 2'b00;
        tick();

        // single request on req0
        rv2 = 2'b01; e1_2 = 16'h0081; e2_2 = 16'h0082; c2 = 2'b00;
        #1 check("t1_ready", 32'(rdy2), 32'h1);
        tick();
        check_res2("t1", 1'b1, 1'b0, 8'h83, 1'b0, 1'b0);

        // overflow on req1 (pointer now 1)
        rv2 = 2'b10; e1_2 = 16'hC000; e2_2 = 16'hC000;
        #1 check("ovf_ready", 32'(rdy2), 32'h2);
        tick();
        check_res2("ovf", 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

        // underflow on req0, carry clear
        rv2 = 2'b01; e1_2 = 16'h0040; e2_2 = 16'h003F; c2 = 2'b00;
        tick();
        check_res2("unf", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);

        // same operands with carry set cancel underflow
        c2 = 2'b01;
        tick();
        check_res2("unf_c", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);

        // both valid every cycle: pointer is 1, so ids go 1,0,1,0
        rv2 = 2'b11; c2 = 2'b00; e1_2 = 16'h9081; e2_2 = 16'h8080;
        for (int k = 0; k < 4; k++) begin
            #1 check("rr_ready", 32'(rdy2), (k % 2 == 0) ? 32'h2 : 32'h1);
            tick();
            check_res2("rr", 1'b1, (k % 2 == 0), (k % 2 == 0) ? 8'h90 : 8'h81, 1'b0, 1'b0);
        end

        // backpressure: result id0/81 held for 3 cycles
        resr2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready", 32'(rdy2), 32'h0);
            check("bp_busy", 32'(busy2), 32'h1);
            tick();
            check_res2("bp", 1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
        end
        resr2 = 1'b1;
        #1 check("bp_rel_ready", 32'(rdy2), 32'h2);
        check("bp_rel_busy", 32'(busy2), 32'h0);
        tick();
        check_res2("bp_rel", 1'b1, 1'b1, 8'h90, 1'b0, 1'b0);

        // one more grant to leave pointer at 1, then hold FULL
        tick();
        check_res2("pre_rst", 1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
        resr2 = 1'b0;
        nRST = 1'b0;
        #1 check("rst_mid_ready", 32'(rdy2), 32'h0);
        tick();
        check_res2("rst_mid", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        nRST = 1'b1; resr2 = 1'b1;
        #1 check("post_rst_ready", 32'(rdy2), 32'h1);
        tick();
        check_res2("post_rst", 1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
        rv2 = 2'b00;

        // three requesters: only req2 valid repeatedly
        rv3 = 3'b100; e1_3 = 24'h810090; e2_3 = 24'h820080;
        for (int k = 0; k < 3; k++) begin
            #1 check("r3_ready", 32'(rdy3), 32'h4);
            tick();
            check("r3_valid", 32'(resv3), 32'h1);
            check("r3_id", 32'(id3), 32'h2);
            check("r3_sum", 32'(sum3), 32'h83);
        end
        // pointer wrapped to 0: req0 wins over req2
        rv3 = 3'b101;
        #1 check("r3_wrap_ready", 32'(rdy3), 32'h1);
        tick();
        check("r3_wrap_id", 32'(id3), 32'h0);
        check("r3_wrap_sum", 32'(sum3), 32'h90);
        rv3 = 3'b000;
        tick();
        check("r3_idle_valid", 32'(resv3), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
